// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged power-on reset sequencer driven by PLL lock qualification
// Optional lock-loss event counter: define RST_SEQ_LOSS_CNT_EN.
module reset_sequencer #(
  parameter int N_LOCK      = 2,
  parameter int N_STAGES    = 3,
  parameter int LOCK_FILTER = 8,
  parameter int HOLD_CYCLES = 1024,
  parameter int STAGE_GAP   = 16,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic [N_LOCK-1:0]   locked,
  input  logic                sw_reset_req,
  output logic [N_STAGES-1:0] n_reset_out,
  output logic                all_released,
  output logic [1:0]          state_dbg,
  output logic [CNT_W-1:0]    loss_count
);

  localparam int REL_SPAN = (N_STAGES - 1) * STAGE_GAP;
  localparam int MAX_LH   = (LOCK_FILTER > HOLD_CYCLES) ? LOCK_FILTER : HOLD_CYCLES;
  localparam int MAXV     = (MAX_LH > REL_SPAN) ? MAX_LH : REL_SPAN;
  localparam int CW       = $clog2(MAXV + 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  logic [N_LOCK-1:0]   lk_meta;
  logic [N_LOCK-1:0]   lk_sync;
  logic                all_lk;
  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N_STAGES-1:0] out_q, out_d;
  logic                rel_q, rel_d;
  logic [N_STAGES-1:0] stage_next;

  // all_lk is registered after the synchroniser so the FSM never sees a raw AND of two async bits
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      lk_meta <= '0;
      lk_sync <= '0;
      all_lk  <= 1'b0;
    end else begin
      lk_meta <= locked;
      lk_sync <= lk_meta;
      all_lk  <= &lk_sync;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      out_q   <= '0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rel_q   <= rel_d;
    end
  end

  // Thermometer shift: releases exactly one more stage, bit 0 first
  always_comb begin
    stage_next    = '0;
    stage_next[0] = 1'b1;
    for (int i = 1; i < N_STAGES; i++) begin
      stage_next[i] = out_q[i-1];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    rel_d   = rel_q;
    case (state_q)
      WAIT_LOCK: begin
        out_d = '0;
        rel_d = 1'b0;
        if (sw_reset_req || !all_lk) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(LOCK_FILTER - 1)) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (!all_lk || sw_reset_req) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
          cnt_d   = '0;
          out_d   = stage_next;
          rel_d   = &stage_next;
          state_d = (&stage_next) ? RUN : RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (!all_lk || sw_reset_req) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          out_d   = '0;
          rel_d   = 1'b0;
        end else if (cnt_q == CW'(STAGE_GAP - 1)) begin
          cnt_d   = '0;
          out_d   = stage_next;
          rel_d   = &stage_next;
          state_d = (&stage_next) ? RUN : RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!all_lk || sw_reset_req) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          out_d   = '0;
          rel_d   = 1'b0;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
        out_d   = '0;
        rel_d   = 1'b0;
      end
    endcase
  end

  assign n_reset_out  = out_q;
  assign all_released = rel_q;
  assign state_dbg    = state_q;

`ifdef RST_SEQ_LOSS_CNT_EN
  logic [CNT_W-1:0] loss_q;
  logic             lost;

  // A lock drop wins over a simultaneous software request, so it is always counted
  assign lost = ((state_q == RELEASE) || (state_q == RUN)) && !all_lk;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      loss_q <= '0;
    end else if (lost && (loss_q != {CNT_W{1'b1}})) begin
      loss_q <= loss_q + 1'b1;
    end
  end

  assign loss_count = loss_q;
`else
  assign loss_count = '0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - self-checking bench for reset_sequencer against a timeline model
module tb_reset_sequencer;

  localparam int NL  = 2;
  localparam int NS  = 3;
  localparam int LF  = 4;
  localparam int HC  = 10;
  localparam int GAP = 3;
  localparam int CW  = 2;
`ifdef RST_SEQ_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          n_reset;
  logic [NL-1:0] locked;
  logic          sw_reset_req;
  logic [NS-1:0] n_reset_out;
  logic          all_released;
  logic [1:0]    state_dbg;
  logic [CW-1:0] loss_count;

  int vectors     = 0;
  int miscompares = 0;

  // Model: prog = edges since HOLD entry (-1 while waiting for lock), clean = filter progress
  int       prog;
  int       clean;
  int       loss;
  bit [2:0] hist;

  always #5 clk = ~clk;

  reset_sequencer #(
    .N_LOCK(NL), .N_STAGES(NS), .LOCK_FILTER(LF),
    .HOLD_CYCLES(HC), .STAGE_GAP(GAP), .CNT_W(CW)
  ) dut (
    .clk(clk), .n_reset(n_reset), .locked(locked), .sw_reset_req(sw_reset_req),
    .n_reset_out(n_reset_out), .all_released(all_released),
    .state_dbg(state_dbg), .loss_count(loss_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    prog  = -1;
    clean = 0;
    loss  = 0;
    hist  = '0;
  endtask

  // The FSM acts on the lock state sampled three edges earlier (2 sync flops + AND register)
  task automatic model_edge(input logic [NL-1:0] lk, input logic sw);
    bit seen;
    seen = hist[2];
    hist = {hist[1:0], &lk};
    if (prog < 0) begin
      if (sw || !seen) clean = 0;
      else if (clean == LF - 1) begin
        prog  = 0;
        clean = 0;
      end else clean++;
    end else if (!seen || sw) begin
      if (!seen && prog >= HC && LOSS_EN && loss < (1 << CW) - 1) loss++;
      prog  = -1;
      clean = 0;
    end else if (prog < HC + (NS - 1) * GAP) begin
      prog++;
    end
  endtask

  task automatic compare_all();
    int rel_n;
    int exp_state;
    rel_n = (prog < HC) ? 0 : (prog - HC) / GAP + 1;
    if (rel_n > NS) rel_n = NS;
    if (prog < 0)        exp_state = 0;
    else if (prog < HC)  exp_state = 1;
    else if (rel_n < NS) exp_state = 2;
    else                 exp_state = 3;
    check("n_reset_out", 32'(n_reset_out), 32'((1 << rel_n) - 1));
    check("all_released", 32'(all_released), 32'(rel_n == NS));
    check("state_dbg", 32'(state_dbg), 32'(exp_state));
    check("loss_count", 32'(loss_count), 32'(loss));
  endtask

  task automatic tick(input logic [NL-1:0] lk, input logic sw);
    locked       = lk;
    sw_reset_req = sw;
    @(posedge clk);
    if (n_reset) model_edge(lk, sw);
    else         model_reset();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  initial begin
    n_reset      = 1'b0;
    locked       = '0;
    sw_reset_req = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    check("rst_out", 32'(n_reset_out), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    // Clean power-up: cycle 0 is the first edge sampling locked=11
    n_reset = 1'b1;
    for (int i = 0; i < 23; i++) begin
      tick(2'b11, 1'b0);
      if (i == 15) check("pwrup_c15", 32'(n_reset_out), 32'b000);
      if (i == 16) check("pwrup_c16", 32'(n_reset_out), 32'b001);
      if (i == 18) check("pwrup_c18", 32'(n_reset_out), 32'b001);
      if (i == 19) check("pwrup_c19", 32'(n_reset_out), 32'b011);
      if (i == 21) check("pwrup_c21_rel", 32'(all_released), 32'd0);
      if (i == 22) begin
        check("pwrup_c22", 32'(n_reset_out), 32'b111);
        check("pwrup_c22_rel", 32'(all_released), 32'd1);
        check("pwrup_c22_state", 32'(state_dbg), 32'd3);
      end
    end

    // One-cycle lock glitch in RUN: abort lands three edges later
    tick(2'b01, 1'b0);
    for (int i = 1; i <= 30; i++) begin
      tick(2'b11, 1'b0);
      if (i == 2) check("glitch_t2", 32'(n_reset_out), 32'b111);
      if (i == 3) begin
        check("glitch_t3", 32'(n_reset_out), 32'b000);
        check("glitch_t3_rel", 32'(all_released), 32'd0);
        check("glitch_loss", 32'(loss_count), LOSS_EN ? 32'd1 : 32'd0);
      end
    end
    check("rerun_state", 32'(state_dbg), 32'd3);

    // Software re-sequence from RUN
    tick(2'b11, 1'b1);
    check("sw_abort", 32'(n_reset_out), 32'b000);
    check("sw_loss", 32'(loss_count), LOSS_EN ? 32'd1 : 32'd0);
    for (int i = 1; i <= 14; i++) begin
      tick(2'b11, 1'b0);
      if (i == 13) check("sw_p13", 32'(n_reset_out), 32'b000);
      if (i == 14) check("sw_p14", 32'(n_reset_out), 32'b001);
    end

    // Asynchronous reset mid-RELEASE, observed before the next clock edge
    n_reset = 1'b0;
    #1;
    model_reset();
    check("async_out", 32'(n_reset_out), 32'b000);
    check("async_state", 32'(state_dbg), 32'd0);
    check("async_loss", 32'(loss_count), 32'd0);
    @(negedge clk);
    tick(2'b11, 1'b0);
    tick(2'b11, 1'b0);
    n_reset = 1'b1;
    for (int i = 0; i < 23; i++) tick(2'b11, 1'b0);
    check("rst2_run", 32'(n_reset_out), 32'b111);

    // Five lock losses from RUN saturate a 2-bit counter
    for (int n = 0; n < 5; n++) begin
      tick(2'b10, 1'b0);
      for (int i = 0; i < 26; i++) tick(2'b11, 1'b0);
    end
    check("sat_loss", 32'(loss_count), LOSS_EN ? 32'd3 : 32'd0);
    check("sat_state", 32'(state_dbg), 32'd3);

    // Randomised lock glitches and software requests, including simultaneous ones
    for (int i = 0; i < 2000; i++) begin
      logic [NL-1:0] lk;
      logic          sw;
      lk = 2'b11;
      for (int b = 0; b < NL; b++) if ($urandom_range(0, 59) == 0) lk[b] = 1'b0;
      sw = ($urandom_range(0, 149) == 0);
      tick(lk, sw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
